// File: rtl/mic3_sampler.sv
// Paces MIC3 sample requests with a divider timer and buffers returned 12-bit
// samples in a first-word-fall-through FIFO with sticky overflow/missed flags.
module mic3_sampler #(
    parameter int SAMPLE_DIV = 2500,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  clear,
    output logic                  read,
    input  logic [11:0]           audio,
    input  logic                  new_data,
    output logic [11:0]           dout,
    input  logic                  pop,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    output logic                  missed
);

    localparam int TW    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [TW-1:0] TERM = TW'(SAMPLE_DIV - 1);

    logic [TW-1:0]         timer;
    logic                  pending;
    logic [DEPTH_LOG2:0]   wr_ptr;
    logic [DEPTH_LOG2:0]   rd_ptr;
    logic [11:0]           mem [DEPTH];

    logic tick;
    logic do_push;
    logic do_pop;
    logic drop;

    // Handshakes: new_data/audio is a valid-only strobe with no backpressure
    // (a sample arriving while full is dropped and flagged); pop is the ready
    // side of the output and only takes effect while empty = 0.
    assign tick    = enable && (timer == TERM);
    assign do_pop  = pop && !empty;
    assign do_push = new_data && (!full || do_pop);
    assign drop    = new_data && full && !pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                   (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    assign count = wr_ptr - rd_ptr;
    assign dout  = mem[rd_ptr[DEPTH_LOG2-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer   <= '0;
            read    <= 1'b0;
            pending <= 1'b0;
            missed  <= 1'b0;
        end else if (clear) begin
            timer   <= '0;
            read    <= 1'b0;
            pending <= 1'b0;
            missed  <= 1'b0;
        end else begin
            if (!enable || timer == TERM)
                timer <= '0;
            else
                timer <= timer + TW'(1);
            read <= tick && !pending;
            // A fresh request wins over a completion landing on the same edge.
            if (tick && !pending)
                pending <= 1'b1;
            else if (new_data)
                pending <= 1'b0;
            if (tick && pending)
                missed <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (drop)
                overflow <= 1'b1;
        end
    end

    // Storage needs no reset: empty masks stale contents.
    always_ff @(posedge clk) begin
        if (do_push && !clear)
            mem[wr_ptr[DEPTH_LOG2-1:0]] <= audio;
    end

endmodule

// File: tb/tb_mic3_sampler.sv
// Directed bench for mic3_sampler: request pacing, FIFO ordering, full/empty
// corner cases, and async reset versus synchronous clear.
`timescale 1ns/1ps
module tb_mic3_sampler;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        clear;
    logic        read;
    logic [11:0] audio;
    logic        new_data;
    logic [11:0] dout;
    logic        pop;
    logic        empty;
    logic        full;
    logic [4:0]  count;
    logic        overflow;
    logic        missed;

    logic        tb_nd;
    logic [11:0] tb_audio;
    logic        mic_nd;
    logic [11:0] mic_audio;
    logic        mic_on;
    int          mic_lat;
    int          mic_cnt;
    logic [11:0] mic_q[$];

    logic [11:0] exp_q[$];
    int          n_checks;
    int          n_pass;
    int          cyc;

    assign new_data = tb_nd | mic_nd;
    assign audio    = mic_nd ? mic_audio : tb_audio;

    mic3_sampler #(.SAMPLE_DIV(64), .DEPTH_LOG2(4)) dut (
        .clk(clk), .rst(rst), .enable(enable), .clear(clear), .read(read),
        .audio(audio), .new_data(new_data), .dout(dout), .pop(pop),
        .empty(empty), .full(full), .count(count), .overflow(overflow),
        .missed(missed)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    // MIC3 model: answers mic_lat cycles after each observed read
    always @(negedge clk) begin
        mic_nd = 1'b0;
        if (rst) begin
            mic_cnt = 0;
        end else if (mic_on && read) begin
            mic_cnt = mic_lat;
        end else if (mic_cnt > 0) begin
            mic_cnt = mic_cnt - 1;
            if (mic_cnt == 0) begin
                mic_nd    = 1'b1;
                mic_audio = (mic_q.size() > 0) ? mic_q.pop_front() : 12'h000;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        exp_q.delete();
    endtask

    task automatic push_word(input logic [11:0] v);
        tb_nd    = 1'b1;
        tb_audio = v;
        @(negedge clk);
        tb_nd    = 1'b0;
    endtask

    task automatic do_pop();
        pop = 1'b1;
        @(negedge clk);
        pop = 1'b0;
    endtask

    task automatic fill16();
        for (int i = 0; i < 16; i++) begin
            push_word(12'(i * 257));
            exp_q.push_back(12'(i * 257));
        end
    endtask

    task automatic wait_read(input string tag, input int budget, output int at);
        logic found;
        found = 1'b0;
        at    = 0;
        for (int k = 0; k < budget && !found; k++) begin
            @(negedge clk);
            if (read) begin
                found = 1'b1;
                at    = cyc;
            end
        end
        check(tag, 32'(found), 32'd1);
    endtask

    task automatic setup_five();
        fill16();
        push_word(12'hABC);
        for (int i = 0; i < 11; i++) begin
            do_pop();
            void'(exp_q.pop_front());
        end
        enable = 1'b1;
        step(10);
        check("pre_count5", 32'(count), 32'd5);
        check("pre_overflow", 32'(overflow), 32'd1);
    endtask

    initial begin
        int c1, c2, c0;
        rst = 1'b1; enable = 1'b0; clear = 1'b0; pop = 1'b0;
        tb_nd = 1'b0; tb_audio = '0; mic_on = 1'b0; mic_lat = 20;
        mic_cnt = 0; mic_nd = 1'b0; mic_audio = '0;
        n_checks = 0; n_pass = 0; cyc = 0;
        step(3);
        rst = 1'b0;
        step(1);
        check("rst_read", 32'(read), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_missed", 32'(missed), 32'd0);

        // 1: fast responder, read every 64 cycles
        mic_q = '{12'h123, 12'h456};
        mic_lat = 20; mic_on = 1'b1; enable = 1'b1;
        wait_read("t1_read1", 100, c1);
        wait_read("t1_read2", 100, c2);
        check("t1_period", 32'(c2 - c1), 32'd64);
        for (int k = 0; k < 40 && count != 5'd2; k++) step(1);
        enable = 1'b0;
        check("t1_count", 32'(count), 32'd2);
        check("t1_missed", 32'(missed), 32'd0);
        check("t1_dout0", 32'(dout), 32'h123);
        do_pop();
        check("t1_dout1", 32'(dout), 32'h456);
        step(70);
        do_clear();

        // 2: slow responder, every second tick skipped
        mic_q = '{12'h321, 12'h654};
        mic_lat = 100; enable = 1'b1;
        wait_read("t2_read1", 100, c1);
        step(60);
        check("t2_missed_early", 32'(missed), 32'd0);
        step(10);
        check("t2_missed_set", 32'(missed), 32'd1);
        wait_read("t2_read2", 200, c2);
        check("t2_period", 32'(c2 - c1), 32'd128);
        enable = 1'b0;
        step(120);
        check("t2_count", 32'(count), 32'd2);
        check("t2_dout", 32'(dout), 32'h321);
        mic_on = 1'b0;
        do_clear();

        // 3: fill, overflow, drain in order
        fill16();
        check("t3_full", 32'(full), 32'd1);
        check("t3_count", 32'(count), 32'd16);
        check("t3_ovf_pre", 32'(overflow), 32'd0);
        push_word(12'hABC);
        check("t3_overflow", 32'(overflow), 32'd1);
        check("t3_count_drop", 32'(count), 32'd16);
        check("t3_head_kept", 32'(dout), 32'h000);
        for (int i = 0; i < 16; i++) begin
            check("t3_drain", 32'(dout), 32'(exp_q.pop_front()));
            do_pop();
        end
        check("t3_empty", 32'(empty), 32'd1);
        check("t3_count0", 32'(count), 32'd0);
        do_clear();

        // 4: push + pop while full
        fill16();
        tb_nd = 1'b1; tb_audio = 12'h777; pop = 1'b1;
        @(negedge clk);
        tb_nd = 1'b0; pop = 1'b0;
        void'(exp_q.pop_front());
        exp_q.push_back(12'h777);
        check("t4_count", 32'(count), 32'd16);
        check("t4_overflow", 32'(overflow), 32'd0);
        check("t4_head", 32'(dout), 32'h101);
        for (int i = 0; i < 16; i++) begin
            check("t4_drain", 32'(dout), 32'(exp_q.pop_front()));
            do_pop();
        end
        check("t4_empty", 32'(empty), 32'd1);
        do_clear();

        // 5: pop on empty, push+pop on empty
        do_pop();
        check("t5_count0", 32'(count), 32'd0);
        check("t5_empty", 32'(empty), 32'd1);
        check("t5_ovf", 32'(overflow), 32'd0);
        tb_nd = 1'b1; tb_audio = 12'h5A5; pop = 1'b1;
        @(negedge clk);
        tb_nd = 1'b0; pop = 1'b0;
        check("t5_count1", 32'(count), 32'd1);
        check("t5_dout", 32'(dout), 32'h5A5);
        push_word(12'h3C3);
        do_pop();
        check("t5_count_after", 32'(count), 32'd1);
        check("t5_dout2", 32'(dout), 32'h3C3);
        do_clear();

        // 6a: asynchronous reset with 5 entries stored
        setup_five();
        #2 rst = 1'b1;
        #1;
        check("t6_rst_count", 32'(count), 32'd0);
        check("t6_rst_empty", 32'(empty), 32'd1);
        check("t6_rst_full", 32'(full), 32'd0);
        check("t6_rst_ovf", 32'(overflow), 32'd0);
        check("t6_rst_read", 32'(read), 32'd0);
        check("t6_rst_missed", 32'(missed), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        enable = 1'b0;
        exp_q.delete();
        step(1);

        // 6b: synchronous clear, one edge later
        setup_five();
        clear = 1'b1;
        #1;
        check("t6_clr_before_edge", 32'(count), 32'd5);
        @(negedge clk);
        clear = 1'b0;
        c0 = cyc;
        check("t6_clr_count", 32'(count), 32'd0);
        check("t6_clr_empty", 32'(empty), 32'd1);
        check("t6_clr_ovf", 32'(overflow), 32'd0);
        check("t6_clr_read", 32'(read), 32'd0);
        wait_read("t6_read_after_clr", 100, c1);
        check("t6_timer_restart", 32'(c1 - c0), 32'd64);
        enable = 1'b0;
        step(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
